n64_poll_controller: RTL and testbench
======================================

Name: n64_poll_controller

Overview:
Host-side master for the single-wire N64 controller bus. It periodically issues the 8-bit poll command (0x01) plus a stop bit on the open-drain data line, then releases the line. It times the device's 32-bit response plus stop bit and decodes it into a button/joystick word for the game logic. It is the sequencer that owns the bus and sits between the paddle-control logic and the pad pin's tristate buffer.

Parameters:
BIT_PERIOD, 40, clocks per bus bit cell.
SHORT_LOW, 10, low time in clocks for a '1' or stop bit driven by the host.
LONG_LOW, 30, low time in clocks for a '0' driven by the host.
SAMPLE_POINT, 20, clocks after a detected falling edge at which an RX bit is sampled.
POLL_INTERVAL, 16000, clocks from end of one transaction to start of the next.
RESP_TIMEOUT, 400, clocks allowed between RX falling edges, including before the first edge.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
poll_en  in  1  level; while high, polls repeat every POLL_INTERVAL
data_in  in  1  raw sampled pad line; asynchronous to clk
data_oe  out  1  1 = drive pad low, 0 = release (pad pulled high externally)
buttons  out  32  last good response; first received bit lands in [31]
valid  out  1  one-clock pulse when buttons is updated
timeout_err  out  1  one-clock pulse on response timeout
busy  out  1  high from TX start until DONE/ERROR exits

Behaviour:
- Reset (async, rst_n low): data_oe=0, buttons=0, valid=0, timeout_err=0, busy=0; state=IDLE; all counters=0. Reset mid-transaction releases the line immediately and does not update buttons.
- data_in passes through a 2-flop synchronizer. A falling edge is sync_q1=1 and sync_q0=0. Decode timing is measured from the detected edge and includes the fixed 2-clock offset.
- IDLE: interval counter runs while poll_en=1 and saturates at POLL_INTERVAL. When it reaches POLL_INTERVAL and the synchronized line is high, go to TX. If the line is low, hold in IDLE until it goes high (stuck-bus guard). If poll_en=0, the counter clears.
- First poll after reset or after poll_en rises waits the full POLL_INTERVAL.
- TX: 9 bit cells, command bits 0x01 sent MSB first, then the stop bit. Each cell is BIT_PERIOD clocks. data_oe=1 for the first LONG_LOW clocks of a '0' cell, or SHORT_LOW clocks of a '1'/stop cell, and 0 for the rest of the cell. busy rises on the first TX clock.
- After the last stop cell, go to RX_WAIT with data_oe=0; data_oe stays 0 in every state other than TX.
- RX_WAIT: a timeout counter clears on entry. On a falling edge, go to RX_SAMPLE. If the counter reaches RESP_TIMEOUT, go to ERROR.
- RX_SAMPLE: count SAMPLE_POINT clocks after the edge. At that clock, synchronized line high = 1, low = 0; shift the bit into a shift register, MSB first. After 32 data bits, the next edge+sample is the stop bit; its value is ignored. Then go to DONE, otherwise return to RX_WAIT.
- Falling edges that arrive during RX_SAMPLE are ignored.
- DONE: buttons <= shift register and valid=1 for one clock, then IDLE.
- ERROR: timeout_err=1 for one clock and buttons is unchanged, then IDLE.
- Both DONE and ERROR exits clear busy and restart the interval counter.
- poll_en falling mid-transaction: the current transaction completes normally and no new one starts.
- Counters are sized $clog2(max+1) and saturate rather than wrap.
- valid and timeout_err never assert in the same clock.

Decomposition:
- Shared package n64_pkg holds:
  - state enum {IDLE, TX, RX_WAIT, RX_SAMPLE, DONE, ERROR};
  - CMD_POLL = 8'h01;
  - RESP_BITS = 32;
  - default timing constants.
- One sub-module, n64_line_sync: the 2-flop synchronizer plus falling-edge detector, resetting to line-high. It is reused by any future N64 bus block.

Test Plan:
- Reset, poll_en=1, responder idle -> after 16000 clocks busy=1. data_oe low-pulse widths are 30,30,30,30,30,30,30,10 and stop 10, each cell 40 clocks. data_oe=0 afterwards.
- Responder returns 0x8000_0001 with '1' = 10 low/30 high and '0' = 30 low/10 high, plus stop bit -> valid pulses once and buttons=32'h8000_0001.
- Responder silent after the command -> timeout_err pulses exactly 400 clocks after RX_WAIT entry; buttons keeps its prior value 32'h8000_0001; next poll follows 16000 clocks later.
- Responder stops after 12 bits -> timeout_err after 400 clocks of silence, no valid pulse, busy drops.
- Data line held low by bench when the interval expires -> no TX and data_oe=0. Release the line -> TX starts within 3 clocks.
- Assert rst_n=0 midway through TX cell 4 -> data_oe=0 in the same clock, buttons=0, and no valid or timeout_err pulse follows.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared types and constants for N64 controller bus blocks: FSM states,
// command/response sizes and the default bus timing in clocks.
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    RX_WAIT,
    RX_SAMPLE,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam int         CMD_BITS  = 8;
  localparam int         RESP_BITS = 32;
  localparam int         TX_IDX_W  = 4;

  localparam int DEF_BIT_PERIOD    = 40;
  localparam int DEF_SHORT_LOW     = 10;
  localparam int DEF_LONG_LOW      = 30;
  localparam int DEF_SAMPLE_POINT  = 20;
  localparam int DEF_POLL_INTERVAL = 16000;
  localparam int DEF_RESP_TIMEOUT  = 400;

  // Cells 0..7 carry the command MSB first; the cell after them is the stop bit ('1').
  function automatic logic tx_cell_bit(input logic [TX_IDX_W-1:0] idx);
    if (idx < TX_IDX_W'(CMD_BITS)) begin
      return CMD_POLL[3'(TX_IDX_W'(CMD_BITS - 1) - idx)];
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the N64 pad line plus a falling-edge detector.
// Every stage resets to the idle (pulled-high) line level.
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic line,
  output logic fall
);

  logic meta;
  logic sync_q0;
  logic sync_q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= 1'b1;
      sync_q0 <= 1'b1;
      sync_q1 <= 1'b1;
    end else begin
      meta    <= data_in;
      sync_q0 <= meta;
      sync_q1 <= sync_q0;
    end
  end

  assign line = sync_q0;
  assign fall = sync_q1 & ~sync_q0;

endmodule

// File: rtl/n64_poll_controller.sv
// Host-side N64 controller bus master: sends the poll command, times and
// decodes the 32-bit response, and reports good data or a response timeout.
module n64_poll_controller
  import n64_pkg::*;
#(
  parameter int BIT_PERIOD    = DEF_BIT_PERIOD,
  parameter int SHORT_LOW     = DEF_SHORT_LOW,
  parameter int LONG_LOW      = DEF_LONG_LOW,
  parameter int SAMPLE_POINT  = DEF_SAMPLE_POINT,
  parameter int POLL_INTERVAL = DEF_POLL_INTERVAL,
  parameter int RESP_TIMEOUT  = DEF_RESP_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 poll_en,
  input  logic                 data_in,
  output logic                 data_oe,
  output logic [RESP_BITS-1:0] buttons,
  output logic                 valid,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam int CW = $clog2(BIT_PERIOD + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam int SW = $clog2(SAMPLE_POINT + 1);
  localparam int RW = $clog2(RESP_BITS + 1);

  state_t                state, state_n;
  logic [IW-1:0]         interval_cnt, interval_n;
  logic [CW-1:0]         cell_cnt, cell_n;
  logic [TX_IDX_W-1:0]   tx_idx, tx_idx_n;
  logic [TW-1:0]         tmo_cnt, tmo_n;
  logic [SW-1:0]         smp_cnt, smp_n;
  logic [RW-1:0]         rx_cnt, rx_n;
  logic [RESP_BITS-1:0]  shift_reg, shift_n;
  logic                  line_hi;
  logic                  line_fall;

  n64_line_sync u_line_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .line   (line_hi),
    .fall   (line_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      interval_cnt <= '0;
      cell_cnt     <= '0;
      tx_idx       <= '0;
      tmo_cnt      <= '0;
      smp_cnt      <= '0;
      rx_cnt       <= '0;
      shift_reg    <= '0;
      buttons      <= '0;
    end else begin
      state        <= state_n;
      interval_cnt <= interval_n;
      cell_cnt     <= cell_n;
      tx_idx       <= tx_idx_n;
      tmo_cnt      <= tmo_n;
      smp_cnt      <= smp_n;
      rx_cnt       <= rx_n;
      shift_reg    <= shift_n;
      if (state == DONE) begin
        buttons <= shift_reg;
      end
    end
  end

  always_comb begin
    state_n    = state;
    interval_n = interval_cnt;
    cell_n     = cell_cnt;
    tx_idx_n   = tx_idx;
    tmo_n      = tmo_cnt;
    smp_n      = smp_cnt;
    rx_n       = rx_cnt;
    shift_n    = shift_reg;
    case (state)
      IDLE: begin
        if (!poll_en) begin
          interval_n = '0;
        end else begin
          if (int'(interval_cnt) < POLL_INTERVAL) begin
            interval_n = interval_cnt + IW'(1);
          end
          // A low line at expiry means the bus is stuck; wait for it to release.
          if (int'(interval_cnt) >= POLL_INTERVAL - 1 && line_hi) begin
            state_n  = TX;
            cell_n   = '0;
            tx_idx_n = '0;
            rx_n     = '0;
            shift_n  = '0;
          end
        end
      end
      TX: begin
        if (int'(cell_cnt) >= BIT_PERIOD - 1) begin
          cell_n = '0;
          if (int'(tx_idx) >= CMD_BITS) begin
            state_n = RX_WAIT;
            tmo_n   = '0;
          end else begin
            tx_idx_n = tx_idx + TX_IDX_W'(1);
          end
        end else begin
          cell_n = cell_cnt + CW'(1);
        end
      end
      RX_WAIT: begin
        if (line_fall) begin
          // The two synchronizer clocks already elapsed since the pad edge.
          state_n = RX_SAMPLE;
          smp_n   = SW'(2);
        end else if (int'(tmo_cnt) >= RESP_TIMEOUT - 1) begin
          state_n = ERROR;
        end else begin
          tmo_n = tmo_cnt + TW'(1);
        end
      end
      RX_SAMPLE: begin
        if (int'(smp_cnt) >= SAMPLE_POINT) begin
          if (int'(rx_cnt) >= RESP_BITS) begin
            state_n = DONE;
          end else begin
            shift_n = {shift_reg[RESP_BITS-2:0], line_hi};
            rx_n    = rx_cnt + RW'(1);
            state_n = RX_WAIT;
            tmo_n   = '0;
          end
        end else begin
          smp_n = smp_cnt + SW'(1);
        end
      end
      DONE, ERROR: begin
        state_n    = IDLE;
        interval_n = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign data_oe     = (state == TX) &&
                       (int'(cell_cnt) < (tx_cell_bit(tx_idx) ? SHORT_LOW : LONG_LOW));
  assign busy        = (state != IDLE);
  assign valid       = (state == DONE);
  assign timeout_err = (state == ERROR);

endmodule

// File: tb/tb_n64_poll_controller.sv
// Directed bench for n64_poll_controller: a bench-side responder pulls the
// shared pad low on top of the DUT's open-drain drive.
module tb_n64_poll_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        poll_en = 1'b0;
  logic        bench_low = 1'b0;
  logic        data_in;
  logic        data_oe;
  logic [31:0] buttons;
  logic        valid;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int valid_count = 0;
  int tmo_count = 0;

  always #5 clk = ~clk;

  // Wired-AND pad with an external pull-up.
  assign data_in = ~(data_oe | bench_low);

  n64_poll_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .poll_en    (poll_en),
    .data_in    (data_in),
    .data_oe    (data_oe),
    .buttons    (buttons),
    .valid      (valid),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (valid) valid_count++;
    if (timeout_err) tmo_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int low_t, input int high_t);
    bench_low = 1'b1;
    repeat (low_t) @(negedge clk);
    bench_low = 1'b0;
    repeat (high_t) @(negedge clk);
  endtask

  task automatic sendWord(input logic [31:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (word[31 - i]) applyStimulus(10, 30);
      else applyStimulus(30, 10);
    end
  endtask

  // Counts idle samples (busy low) and returns on the first TX sample.
  task automatic measureIdle(output int len);
    int guard;
    guard = 0;
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    len = 0;
    while (!busy && len < 20000) begin
      len++;
      @(negedge clk);
    end
  endtask

  logic oe_log [0:359];
  int   len;
  int   k;
  int   v0;
  int   t0;
  int   run;
  int   ones;
  int   exp_low;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_data_oe", data_oe, 0);
    checkOutput("reset_buttons", buttons, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_busy", busy, 0);

    rst_n   = 1'b1;
    poll_en = 1'b1;
    measureIdle(len);
    checkOutput("first_poll_delay", len, 16000);

    // Poll 1: capture the command waveform, then answer 0x8000_0001.
    for (int i = 0; i < 360; i++) begin
      oe_log[i] = data_oe;
      @(negedge clk);
    end
    for (int c = 0; c < 9; c++) begin
      run  = 0;
      ones = 0;
      while (run < 40 && oe_log[c * 40 + run]) run++;
      for (int j = 0; j < 40; j++) if (oe_log[c * 40 + j]) ones++;
      exp_low = (c >= 7) ? 10 : 30;
      checkOutput($sformatf("tx_cell%0d_low_run", c), run, exp_low);
      checkOutput($sformatf("tx_cell%0d_low_total", c), ones, exp_low);
    end
    checkOutput("rx_wait_released", data_oe, 0);
    checkOutput("rx_wait_busy", busy, 1);

    v0 = valid_count;
    t0 = tmo_count;
    sendWord(32'h8000_0001, 32);
    applyStimulus(10, 0);
    measureIdle(len);
    checkOutput("resp_valid_pulses", valid_count - v0, 1);
    checkOutput("resp_buttons", buttons, 32'h8000_0001);
    checkOutput("resp_no_timeout", tmo_count - t0, 0);
    checkOutput("poll_interval_after_done", len, 16000);

    // Poll 2: silent responder; RX_WAIT starts 360 clocks into the transaction.
    repeat (360) @(negedge clk);
    v0 = valid_count;
    k = 0;
    while (!timeout_err && k < 600) begin
      @(negedge clk);
      k++;
    end
    checkOutput("silent_timeout_clocks", k, 400);
    checkOutput("silent_buttons_kept", buttons, 32'h8000_0001);
    @(negedge clk);
    checkOutput("silent_busy_dropped", busy, 0);
    checkOutput("silent_no_valid", valid_count - v0, 0);
    measureIdle(len);
    checkOutput("poll_interval_after_error", len, 16000);

    // Poll 3: responder quits after 12 bits. From the last pad fall: 2 sync
    // clocks, sample 20 clocks after the edge, then 400 silent clocks -> 422.
    repeat (360) @(negedge clk);
    v0 = valid_count;
    sendWord(32'hA5C0_0000, 12);
    k = 40;
    while (!timeout_err && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("partial_timeout_clocks", k, 422);
    @(negedge clk);
    checkOutput("partial_busy_dropped", busy, 0);
    checkOutput("partial_no_valid", valid_count - v0, 0);
    checkOutput("partial_buttons_kept", buttons, 32'h8000_0001);

    // Poll 4: pad held low across interval expiry.
    repeat (15000) @(negedge clk);
    bench_low = 1'b1;
    repeat (1100) @(negedge clk);
    checkOutput("stuck_no_tx_busy", busy, 0);
    checkOutput("stuck_no_tx_oe", data_oe, 0);
    bench_low = 1'b0;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("stuck_release_within_3", (k >= 1 && k <= 3), 1);

    // Reset halfway through the fourth cell (a '0' cell, still driving low).
    repeat (140) @(negedge clk);
    checkOutput("cell4_mid_drive", data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midtx_reset_oe", data_oe, 0);
    checkOutput("midtx_reset_busy", busy, 0);
    checkOutput("midtx_reset_buttons", buttons, 0);
    v0 = valid_count;
    t0 = tmo_count;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    checkOutput("post_reset_no_valid", valid_count - v0, 0);
    checkOutput("post_reset_no_timeout", tmo_count - t0, 0);
    checkOutput("post_reset_oe_idle", data_oe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
